// File: rtl/fs2_inst_queue.sv
// Instruction queue: compacts fetch bundles (truncated after first taken lane), dequeues up to DEQ_WIDTH per cycle.
// Latency: accepted packet visible on deqPkt_o the next cycle; redirect_o pulses one cycle after a taken lane is kept.
// Backpressure: fetchReady_o drops unless a full bundle fits; optional stall counter under `define FS2_STALL_CNT_EN.
module fs2_inst_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int DEQ_WIDTH   = 4,
  parameter int PKT_W       = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  input  logic [FETCH_WIDTH-1:0]             laneValid_i,
  input  logic [FETCH_WIDTH-1:0]             laneTaken_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]       pkt_i,
  output logic                               fetchReady_o,
  output logic [DEQ_WIDTH-1:0]               deqValid_o,
  output logic [DEQ_WIDTH*PKT_W-1:0]         deqPkt_o,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]     deqReq_i,
  output logic [$clog2(DEPTH+1)-1:0]         count_o,
  output logic                               redirect_o,
  output logic [$clog2(FETCH_WIDTH)-1:0]     redirectLane_o
`ifdef FS2_STALL_CNT_EN
  ,
  output logic [31:0]                        stallCnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(FETCH_WIDTH);
  localparam int OW = $clog2(FETCH_WIDTH + 1);

  logic [PKT_W-1:0]       mem [DEPTH];
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [CW-1:0]          count;
  logic                   redirect;
  logic [LW-1:0]          redirectLane;

  logic [FETCH_WIDTH-1:0] keep;
  logic                   takenHit;
  logic [LW-1:0]          takenLane;
  logic [OW-1:0]          laneOff [FETCH_WIDTH];
  logic [OW-1:0]          nKeep;
  logic                   accept;
  logic [CW-1:0]          nEnq;
  logic [CW-1:0]          avail;
  logic [CW-1:0]          deqReqExt;
  logic [CW-1:0]          nDeq;

  // Keep lanes up to and including the first valid predicted-taken lane.
  always_comb begin
    logic blocked;
    keep      = '0;
    takenHit  = 1'b0;
    takenLane = '0;
    blocked   = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (laneValid_i[i] && !blocked) begin
        keep[i] = 1'b1;
        if (laneTaken_i[i]) begin
          blocked   = 1'b1;
          takenHit  = 1'b1;
          takenLane = LW'(i);
        end
      end
    end
  end

  // Each kept lane lands at tail plus the number of kept lanes below it.
  always_comb begin
    logic [OW-1:0] acc;
    acc = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      laneOff[i] = acc;
      acc        = acc + OW'(keep[i]);
    end
    nKeep = acc;
  end

  assign fetchReady_o = (count <= CW'(DEPTH - FETCH_WIDTH)) & ~flush_i;
  assign accept       = fetchValid_i & fetchReady_o;
  assign nEnq         = accept ? CW'(nKeep) : '0;

  assign avail     = (count > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : count;
  assign deqReqExt = CW'(deqReq_i);
  assign nDeq      = (deqReqExt < avail) ? deqReqExt : avail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      redirect     <= 1'b0;
      redirectLane <= '0;
    end else if (flush_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      redirect     <= 1'b0;
      redirectLane <= '0;
    end else begin
      head         <= head + AW'(nDeq);
      tail         <= tail + AW'(nEnq);
      count        <= count + nEnq - nDeq;
      redirect     <= accept & takenHit;
      redirectLane <= (accept && takenHit) ? takenLane : '0;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (keep[i]) begin
          mem[tail + AW'(laneOff[i])] <= pkt_i[i*PKT_W +: PKT_W];
        end
      end
    end
  end

  always_comb begin
    deqValid_o = '0;
    deqPkt_o   = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      deqValid_o[k]             = (count > CW'(k));
      deqPkt_o[k*PKT_W +: PKT_W] = mem[head + AW'(k)];
    end
  end

  assign count_o        = count;
  assign redirect_o     = redirect;
  assign redirectLane_o = redirectLane;

`ifdef FS2_STALL_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (fetchValid_i && !fetchReady_o && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign stallCnt_o = stallCnt;
`endif

endmodule
